// File: rtl/dffram_port_arbiter_pkg.sv
// rtl/dffram_port_arbiter_pkg.sv - shared constants for the mgmt DFFRAM arbiter
// Return-tag encoding and default geometry, shared with the DFFRAM wrapper.
package dffram_port_arbiter_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 32;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_HK   = 2'd2;

endpackage

// File: rtl/dffram_port_arbiter_if.sv
// rtl/dffram_port_arbiter_if.sv - CPU, housekeeping and DFFRAM signal bundle
// master is the requester/RAM side, slave is the arbiter.
interface dffram_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          cpu_en;
  logic [3:0]    cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;

  logic          hk_req;
  logic [AW-1:0] hk_addr;
  logic          hk_gnt;
  logic [DW-1:0] hk_rdata;
  logic          hk_rvalid;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport master (
    output cpu_en, cpu_we, cpu_addr, cpu_wdata, hk_req, hk_addr, ram_rdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid, hk_gnt, hk_rdata, hk_rvalid,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  cpu_en, cpu_we, cpu_addr, cpu_wdata, hk_req, hk_addr, ram_rdata,
    output cpu_stall, cpu_rdata, cpu_rvalid, hk_gnt, hk_rdata, hk_rvalid,
    output ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dffram_arb_starve_ctr.sv
// rtl/dffram_arb_starve_ctr.sv - saturating wait counter for a low-priority requester
// expired_o rises once a pending request has been refused MAX_WAIT times in a row.
module dffram_arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic core_clk_i,
  input  logic core_rstn_i,
  input  logic req_i,
  input  logic gnt_i,
  output logic expired_o
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge core_clk_i or negedge core_rstn_i) begin
    if (!core_rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= CNT_MAX);

endmodule

// File: rtl/dffram_port_arbiter.sv
// rtl/dffram_port_arbiter.sv - CPU-priority arbiter sharing the mgmt DFFRAM with a housekeeping reader
// Grant is combinational; a one-entry return tag routes the RAM's next-cycle data to its owner.
module dffram_port_arbiter
  import dffram_port_arbiter_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic                  core_clk_i,
  input  logic                  core_rstn_i,
  dffram_port_arbiter_if.slave  bus
);

  logic          hk_win, cpu_win, starve_expired;
  logic          ram_en_d;
  logic [3:0]    ram_we_d;
  logic [AW-1:0] ram_addr_d;
  logic [DW-1:0] ram_wdata_d;
  logic [1:0]    rd_owner_d, rd_owner_q;
  logic [DW-1:0] hk_rdata_d, hk_rdata_q;
  logic          hk_rvalid_d, hk_rvalid_q;

  dffram_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .core_clk_i  (core_clk_i),
    .core_rstn_i (core_rstn_i),
    .req_i       (bus.hk_req),
    .gnt_i       (hk_win),
    .expired_o   (starve_expired)
  );

  assign hk_win  = bus.hk_req && (!bus.cpu_en || starve_expired);
  assign cpu_win = bus.cpu_en && !hk_win;

  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 4'h0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    rd_owner_d  = OWN_NONE;
    if (hk_win) begin
      ram_en_d   = 1'b1;
      ram_addr_d = bus.hk_addr;
      rd_owner_d = OWN_HK;
    end else if (cpu_win) begin
      ram_en_d    = 1'b1;
      ram_we_d    = bus.cpu_we;
      ram_addr_d  = bus.cpu_addr;
      ram_wdata_d = bus.cpu_wdata;
      rd_owner_d  = (bus.cpu_we == 4'h0) ? OWN_CPU : OWN_NONE;
    end
  end

  // hk data is captured one cycle after the RAM returns it, hence the N+2 pulse.
  assign hk_rvalid_d = (rd_owner_q == OWN_HK);
  assign hk_rdata_d  = hk_rvalid_d ? bus.ram_rdata : hk_rdata_q;

  always_ff @(posedge core_clk_i or negedge core_rstn_i) begin
    if (!core_rstn_i) begin
      rd_owner_q  <= OWN_NONE;
      hk_rdata_q  <= '0;
      hk_rvalid_q <= 1'b0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      hk_rdata_q  <= hk_rdata_d;
      hk_rvalid_q <= hk_rvalid_d;
    end
  end

  assign bus.ram_en     = ram_en_d;
  assign bus.ram_we     = ram_we_d;
  assign bus.ram_addr   = ram_addr_d;
  assign bus.ram_wdata  = ram_wdata_d;
  assign bus.cpu_stall  = bus.cpu_en && hk_win;
  assign bus.hk_gnt     = hk_win;
  assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign bus.cpu_rdata  = (rd_owner_q == OWN_CPU) ? bus.ram_rdata : '0;
  assign bus.hk_rdata   = hk_rdata_q;
  assign bus.hk_rvalid  = hk_rvalid_q;

endmodule

// File: tb/tb_dffram_port_arbiter.sv
// tb/tb_dffram_port_arbiter.sv - directed vector bench for dffram_port_arbiter
// Includes a behavioural DFFRAM (byte writes, registered read data).
module tb_dffram_port_arbiter;
  import dffram_port_arbiter_pkg::*;

  localparam int AW = DEF_AW;
  localparam int DW = DEF_DW;
  localparam int MAX_WAIT = 4;

  logic core_clk = 1'b0;
  logic core_rstn = 1'b0;
  always #5 core_clk = ~core_clk;

  dffram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dffram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .core_clk_i  (core_clk),
    .core_rstn_i (core_rstn),
    .bus         (bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge core_clk) begin
    if (bus.ram_en) begin
      bus.ram_rdata <= mem[bus.ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic        ce;
    logic [3:0]  cwe;
    logic [7:0]  ca;
    logic [31:0] cwd;
    logic        hr;
    logic [7:0]  ha;
    logic        e_stall;
    logic        e_gnt;
    logic        e_ren;
    logic [3:0]  e_rwe;
    logic [7:0]  e_raddr;
    logic [31:0] e_rwd;
    logic        e_crv;
    logic [31:0] e_crd;
    logic        e_hrv;
    logic [31:0] e_hrd;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int got;
  vec_t vecs[22];

  function automatic vec_t mk(logic ce, logic [3:0] cwe, logic [7:0] ca, logic [31:0] cwd,
                              logic hr, logic [7:0] ha,
                              logic st, logic gn, logic ren, logic [3:0] rwe, logic [7:0] ra,
                              logic [31:0] rwd, logic crv, logic [31:0] crd,
                              logic hrv, logic [31:0] hrd);
    vec_t v;
    v.ce = ce; v.cwe = cwe; v.ca = ca; v.cwd = cwd; v.hr = hr; v.ha = ha;
    v.e_stall = st; v.e_gnt = gn; v.e_ren = ren; v.e_rwe = rwe; v.e_raddr = ra;
    v.e_rwd = rwd; v.e_crv = crv; v.e_crd = crd; v.e_hrv = hrv; v.e_hrd = hrd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.cpu_en = v.ce; bus.cpu_we = v.cwe; bus.cpu_addr = v.ca; bus.cpu_wdata = v.cwd;
    bus.hk_req = v.hr; bus.hk_addr = v.ha;
  endtask

  task automatic idle();
    bus.cpu_en = 1'b0; bus.cpu_we = 4'h0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.hk_req = 1'b0; bus.hk_addr = '0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, " stall"}, 32'(bus.cpu_stall), 0);
    chk({tag, " gnt"}, 32'(bus.hk_gnt), 0);
    chk({tag, " ram_en"}, 32'(bus.ram_en), 0);
    chk({tag, " ram_we"}, 32'(bus.ram_we), 0);
    chk({tag, " ram_addr"}, 32'(bus.ram_addr), 0);
    chk({tag, " ram_wdata"}, bus.ram_wdata, 0);
    chk({tag, " cpu_rvalid"}, 32'(bus.cpu_rvalid), 0);
    chk({tag, " cpu_rdata"}, bus.cpu_rdata, 0);
    chk({tag, " hk_rvalid"}, 32'(bus.hk_rvalid), 0);
    chk({tag, " hk_rdata"}, bus.hk_rdata, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE_0000 | i;

    vecs[0]  = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,0,0,4'h0,8'h00,32'h0,        0,32'h0,        0,32'h0);
    vecs[1]  = mk(1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 8'h00, 0,0,1,4'hF,8'h10,32'hDEADBEEF, 0,32'h0,        0,32'h0);
    vecs[2]  = mk(1, 4'h0, 8'h10, 32'h0,        0, 8'h00, 0,0,1,4'h0,8'h10,32'h0,        0,32'h0,        0,32'h0);
    vecs[3]  = mk(1, 4'h2, 8'h10, 32'h0000AB00, 0, 8'h00, 0,0,1,4'h2,8'h10,32'h0000AB00, 1,32'hDEADBEEF, 0,32'h0);
    vecs[4]  = mk(1, 4'h0, 8'h10, 32'h0,        0, 8'h00, 0,0,1,4'h0,8'h10,32'h0,        0,32'h0,        0,32'h0);
    vecs[5]  = mk(0, 4'h0, 8'h00, 32'h0,        1, 8'h10, 0,1,1,4'h0,8'h10,32'h0,        1,32'hDEADABEF, 0,32'h0);
    vecs[6]  = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,0,0,4'h0,8'h00,32'h0,        0,32'h0,        0,32'h0);
    vecs[7]  = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,0,0,4'h0,8'h00,32'h0,        0,32'h0,        1,32'hDEADABEF);
    vecs[8]  = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,0,0,4'h0,8'h00,32'h0,        0,32'h0,        0,32'hDEADABEF);
    vecs[9]  = mk(1, 4'h0, 8'h01, 32'h0,        0, 8'h00, 0,0,1,4'h0,8'h01,32'h0,        0,32'h0,        0,32'hDEADABEF);
    vecs[10] = mk(0, 4'h0, 8'h00, 32'h0,        1, 8'h02, 0,1,1,4'h0,8'h02,32'h0,        1,32'hC0DE0001, 0,32'hDEADABEF);
    vecs[11] = mk(1, 4'h0, 8'h03, 32'h0,        0, 8'h00, 0,0,1,4'h0,8'h03,32'h0,        0,32'h0,        0,32'hDEADABEF);
    vecs[12] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,0,0,4'h0,8'h00,32'h0,        1,32'hC0DE0003, 1,32'hC0DE0002);
    vecs[13] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,0,0,4'h0,8'h00,32'h0,        0,32'h0,        0,32'hC0DE0002);
    vecs[14] = mk(1, 4'h0, 8'h04, 32'h0,        1, 8'h05, 0,0,1,4'h0,8'h04,32'h0,        0,32'h0,        0,32'hC0DE0002);
    vecs[15] = mk(1, 4'h0, 8'h06, 32'h0,        1, 8'h05, 0,0,1,4'h0,8'h06,32'h0,        1,32'hC0DE0004, 0,32'hC0DE0002);
    vecs[16] = mk(1, 4'h0, 8'h07, 32'h0,        1, 8'h05, 0,0,1,4'h0,8'h07,32'h0,        1,32'hC0DE0006, 0,32'hC0DE0002);
    vecs[17] = mk(1, 4'h0, 8'h08, 32'h0,        1, 8'h05, 0,0,1,4'h0,8'h08,32'h0,        1,32'hC0DE0007, 0,32'hC0DE0002);
    vecs[18] = mk(1, 4'h0, 8'h09, 32'h0,        1, 8'h05, 1,1,1,4'h0,8'h05,32'h0,        1,32'hC0DE0008, 0,32'hC0DE0002);
    vecs[19] = mk(1, 4'h0, 8'h09, 32'h0,        0, 8'h00, 0,0,1,4'h0,8'h09,32'h0,        0,32'h0,        0,32'hC0DE0002);
    vecs[20] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,0,0,4'h0,8'h00,32'h0,        1,32'hC0DE0009, 1,32'hC0DE0005);
    vecs[21] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,0,0,4'h0,8'h00,32'h0,        0,32'h0,        0,32'hC0DE0005);

    idle();
    repeat (2) @(posedge core_clk);
    #1 core_rstn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i]);
      @(negedge core_clk);
      chk($sformatf("row%0d cpu_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
      chk($sformatf("row%0d hk_gnt", i), 32'(bus.hk_gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("row%0d ram_en", i), 32'(bus.ram_en), 32'(vecs[i].e_ren));
      chk($sformatf("row%0d ram_we", i), 32'(bus.ram_we), 32'(vecs[i].e_rwe));
      chk($sformatf("row%0d ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].e_raddr));
      chk($sformatf("row%0d ram_wdata", i), bus.ram_wdata, vecs[i].e_rwd);
      chk($sformatf("row%0d cpu_rvalid", i), 32'(bus.cpu_rvalid), 32'(vecs[i].e_crv));
      chk($sformatf("row%0d cpu_rdata", i), bus.cpu_rdata, vecs[i].e_crd);
      chk($sformatf("row%0d hk_rvalid", i), 32'(bus.hk_rvalid), 32'(vecs[i].e_hrv));
      chk($sformatf("row%0d hk_rdata", i), bus.hk_rdata, vecs[i].e_hrd);
      @(posedge core_clk);
      #1;
    end

    // hk grant, then reset while its read is in flight
    bus.hk_req = 1'b1; bus.hk_addr = 8'h10;
    @(negedge core_clk);
    chk("rst_pre hk_gnt", 32'(bus.hk_gnt), 1);
    @(posedge core_clk);
    #1;
    idle();
    core_rstn = 1'b0;
    #1;
    chk_all_zero("in_reset");
    repeat (2) begin
      @(negedge core_clk);
      chk("in_reset hk_rvalid", 32'(bus.hk_rvalid), 0);
    end
    @(posedge core_clk);
    #1 core_rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge core_clk);
      chk_all_zero($sformatf("post_rst%0d", i));
    end
    @(posedge core_clk);
    #1;

    // partial starvation, then reset: the wait count must restart from zero
    for (int i = 0; i < 3; i++) begin
      bus.cpu_en = 1'b1; bus.cpu_addr = 8'h40; bus.hk_req = 1'b1; bus.hk_addr = 8'h30;
      @(negedge core_clk);
      chk($sformatf("pre_rst_contend%0d hk_gnt", i), 32'(bus.hk_gnt), 0);
      @(posedge core_clk);
      #1;
    end
    idle();
    core_rstn = 1'b0;
    @(posedge core_clk);
    #1 core_rstn = 1'b1;

    got = 0;
    for (int i = 1; i <= 8 && got == 0; i++) begin
      bus.cpu_en = 1'b1; bus.cpu_we = 4'h0; bus.cpu_addr = AW'(8'h20 + i);
      bus.hk_req = 1'b1; bus.hk_addr = 8'h30;
      @(negedge core_clk);
      if (bus.hk_gnt) got = i;
      @(posedge core_clk);
      #1;
    end
    chk("starve_bound grant_cycle", 32'(got), 32'(MAX_WAIT + 1));

    bus.hk_req = 1'b0;
    @(negedge core_clk);
    chk("resume cpu_stall", 32'(bus.cpu_stall), 0);
    chk("resume ram_addr", 32'(bus.ram_addr), 32'h25);
    chk("resume cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    @(posedge core_clk);
    #1;
    idle();
    @(negedge core_clk);
    chk("resume hk_rvalid", 32'(bus.hk_rvalid), 1);
    chk("resume hk_rdata", bus.hk_rdata, 32'hC0DE0030);
    chk("resume cpu_rvalid2", 32'(bus.cpu_rvalid), 1);
    chk("resume cpu_rdata", bus.cpu_rdata, 32'hC0DE0025);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dffram_port_arbiter.md
Name: dffram_port_arbiter

Overview:
- Shares the single-port management DFFRAM (byte write enables, 1-cycle read latency) between two requesters: the CPU memory port and a housekeeping read-only port.
- The CPU has fixed priority. A starvation counter guarantees the housekeeping port a slot within MAX_WAIT cycles of contention.
- Sits between mgmt_core's DFFRAM interface and the DFFRAM macro, entirely in the core clock domain.

Parameters:
AW, 8, RAM word-address width
DW, 32, RAM data width (must be 32; byte enables are 4 bits)
MAX_WAIT, 4, contended cycles a pending hk request waits before it preempts the CPU; 0 = hk always wins

Ports:
core_clk  in  1  core clock; all state on rising edge
core_rstn  in  1  asynchronous active-low reset
cpu_en  in  1  CPU access request; held by the CPU while cpu_stall=1
cpu_we  in  4  CPU byte write enables; 0 = read
cpu_addr  in  AW  CPU word address
cpu_wdata  in  DW  CPU write data
cpu_stall  out  1  CPU request not accepted this cycle
cpu_rdata  out  DW  CPU read data
cpu_rvalid  out  1  cpu_rdata valid this cycle
hk_req  in  1  housekeeping read request; held until hk_gnt
hk_addr  in  AW  housekeeping word address
hk_gnt  out  1  hk request accepted this cycle
hk_rdata  out  DW  registered hk read data; holds until next hk read completes
hk_rvalid  out  1  one-cycle pulse: hk_rdata updated
ram_en  out  1  DFFRAM EN
ram_we  out  4  DFFRAM WE
ram_addr  out  AW  DFFRAM A
ram_wdata  out  DW  DFFRAM Di
ram_rdata  in  DW  DFFRAM Do; valid the cycle after a read enable

Behaviour:
- Grant is combinational, evaluated every cycle.
  - hk_win = hk_req && (!cpu_en || starve_cnt >= MAX_WAIT)
  - cpu_win = cpu_en && !hk_win
- Stall and grant outputs:
  - cpu_stall = cpu_en && hk_win
  - hk_gnt = hk_win
  - Both are 0 when the corresponding request is low.
- RAM drive:
  - cpu_win: ram_en=1, ram_we=cpu_we, ram_addr=cpu_addr, ram_wdata=cpu_wdata.
  - hk_win: ram_en=1, ram_we=0, ram_addr=hk_addr, ram_wdata=0.
  - Idle: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - ram_we is never nonzero when ram_en=0.
- starve_cnt (width clog2(MAX_WAIT+1), min 1 bit):
  - Increments, saturating at MAX_WAIT, when hk_req && !hk_gnt.
  - Clears to 0 on hk_gnt or on !hk_req.
  - Bound: a held hk_req is granted at most MAX_WAIT+1 cycles after assertion, whatever the CPU traffic.
- Return tag, rd_owner register with encoding NONE/CPU/HK, loaded every cycle:
  - CPU when cpu_win && cpu_we==0.
  - HK when hk_win.
  - NONE otherwise, including CPU writes.
- CPU return path:
  - cpu_rvalid = (rd_owner==CPU).
  - cpu_rdata = ram_rdata when rd_owner==CPU, else 0 (combinational).
  - Latency: CPU read accepted in cycle N gives data in N+1.
- HK return path:
  - When rd_owner==HK, hk_rdata <= ram_rdata at the end of N+1, and hk_rvalid pulses for exactly one cycle in N+2.
  - hk_rdata holds its value otherwise.
  - Latency: hk_gnt in N gives hk_rvalid in N+2.
- Back-to-back accesses:
  - Every cycle can carry a new grant.
  - Returns are pipelined with no bubbles.
  - An hk read may be granted on the cycle an earlier CPU read returns, and the reverse.
- Simultaneous requests with starve_cnt < MAX_WAIT: the CPU wins and hk waits.
- Reset:
  - On reset assertion: starve_cnt=0, rd_owner=NONE, hk_rdata=0, hk_rvalid=0.
  - On reset assertion: every combinational output is 0 while requests are 0.
  - A read in flight when reset asserts is dropped; no rvalid follows deassertion.
- No write-to-read forwarding. The DFFRAM's own read-during-write semantics apply.

Decomposition:
- Shared package holds:
  - rd_owner encoding localparams: OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_HK=2'd2.
  - Default AW/DW constants, shared with the DFFRAM wrapper.
- One sub-module: dffram_arb_starve_ctr.
  - Parameter: MAX_WAIT.
  - Inputs: core_clk, core_rstn, req, gnt.
  - Output: expired (starve_cnt >= MAX_WAIT).
  - Reused by later multi-requester arbiters.
- Grant muxing and the return pipeline stay in the top module.

Test Plan:
- CPU only: write cpu_we=4'hF addr 8'h10 data 32'hDEADBEEF, then read 8'h10. Expect:
  - cpu_stall=0 throughout.
  - cpu_rvalid=1 the cycle after the read with cpu_rdata=32'hDEADBEEF.
  - No cpu_rvalid for the write.
- Byte write: cpu_we=4'b0010 data 32'h0000AB00 onto 32'hDEADBEEF, then read. Expect cpu_rdata=32'hDEADABEF.
- HK only: hk_req addr 8'h10. Expect:
  - hk_gnt in the same cycle.
  - hk_rvalid one-cycle pulse 2 cycles later with hk_rdata=32'hDEADABEF, held afterwards.
  - ram_we=0.
- Contention, MAX_WAIT=4: CPU reads every cycle, hk_req held. Expect:
  - cpu_stall=0 and hk_gnt=0 for 4 cycles.
  - hk_gnt=1 with cpu_stall=1 in the 5th cycle.
  - The CPU request is accepted the next cycle.
  - Returns go to the correct owners.
- Interleave: CPU read A=8'h01, hk read A=8'h02, CPU read A=8'h03 on consecutive cycles (CPU idle in the hk cycle). Expect:
  - cpu_rvalid in cycles 1 and 3.
  - hk_rvalid in cycle 3 with the correct data.
  - No cross-routing.
- Reset mid-flight: assert core_rstn=0 the cycle after an hk grant. Expect:
  - hk_rvalid never pulses.
  - hk_rdata=0 and starve_cnt=0.
  - All outputs 0 with requests low.
  - Normal operation resumes after release.
